// File: rtl/vga_stream_master.sv
// Avalon-ST video test-pattern source: one header beat plus H_ACTIVE*V_ACTIVE pixel beats per frame.
// Define VGA_STREAM_CTRL_PKT_EN to precede every frame with a video control packet.
module vga_stream_master #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned COLOR_BITS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_color,
    output logic [3*COLOR_BITS-1:0] m_data,
    output logic                    m_startofpacket,
    output logic                    m_endofpacket,
    output logic [1:0]              m_empty,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    frame_done,
    output logic [15:0]             frame_count
);
    localparam int unsigned CB = COLOR_BITS;
    localparam int unsigned DW = 3 * CB;
    localparam int unsigned BW = (H_ACTIVE < 8) ? 1 : H_ACTIVE / 8;
    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, PIXELS} state_t;

    state_t        state_q, state_d;
    logic [15:0]   x_q, x_d, y_q, y_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] solid_q, solid_d;
    logic [DW-1:0] data_q, data_d;
    logic          sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
    logic          done_q, done_d;
    logic [15:0]   count_q, count_d;

    logic          load, last_px, go_vid, go_pix;
    logic [2:0]    bar;
    logic [DW-1:0] pix;

`ifdef VGA_STREAM_CTRL_PKT_EN
    localparam logic [15:0] W_DIM = 16'(H_ACTIVE);
    localparam logic [15:0] H_DIM = 16'(V_ACTIVE);

    logic [1:0] ctrl_idx_q, ctrl_idx_d;

    // One nibble in the low bits of each colour symbol, symbol 0 lowest.
    function automatic logic [DW-1:0] sym3(input logic [3:0] s0, input logic [3:0] s1,
                                           input logic [3:0] s2);
        logic [DW-1:0] d;
        d = '0;
        d[3:0]           = s0;
        d[CB+3:CB]       = s1;
        d[2*CB+3:2*CB]   = s2;
        return d;
    endfunction
`endif

    // Bar index as the number of bar boundaries at or left of x; the last bar takes the remainder.
    always_comb begin
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(x_q) >= k * BW) begin
                bar = bar + 3'd1;
            end
        end
        case (mode_q)
            2'd0:    pix = solid_q;
            2'd1:    pix = {{CB{~bar[1]}}, {CB{~bar[2]}}, {CB{~bar[0]}}};
            2'd2:    pix = {CB'(x_q), CB'(y_q), CB'(x_q ^ y_q)};
            default: pix = (x_q[5] ^ y_q[5]) ? '0 : '1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        solid_d = solid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        count_d = count_q;
`ifdef VGA_STREAM_CTRL_PKT_EN
        ctrl_idx_d = ctrl_idx_q;
`endif
        go_vid  = 1'b0;
        go_pix  = 1'b0;
        load    = !valid_q || m_ready;
        last_px = (x_q == X_LAST) && (y_q == Y_LAST);

        if (valid_q && m_ready && eop_q && state_q == PIXELS) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
        end

        if (load) begin
            case (state_q)
                IDLE, PIXELS: begin
                    if (state_q == PIXELS && !eop_q) begin
                        go_pix = 1'b1;
                    end else if (enable) begin
`ifdef VGA_STREAM_CTRL_PKT_EN
                        state_d     = CTRL_HDR;
                        data_d      = '0;
                        data_d[3:0] = 4'hF;
                        sop_d       = 1'b1;
                        eop_d       = 1'b0;
                        valid_d     = 1'b1;
                        ctrl_idx_d  = '0;
`else
                        go_vid = 1'b1;
`endif
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end
                end
`ifdef VGA_STREAM_CTRL_PKT_EN
                CTRL_HDR: begin
                    state_d    = CTRL_DATA;
                    ctrl_idx_d = '0;
                    data_d     = sym3(W_DIM[15:12], W_DIM[11:8], W_DIM[7:4]);
                    sop_d      = 1'b0;
                    eop_d      = 1'b0;
                end
                CTRL_DATA: begin
                    case (ctrl_idx_q)
                        2'd0: begin
                            data_d     = sym3(W_DIM[3:0], H_DIM[15:12], H_DIM[11:8]);
                            ctrl_idx_d = 2'd1;
                        end
                        2'd1: begin
                            data_d     = sym3(H_DIM[7:4], H_DIM[3:0], 4'h3);
                            eop_d      = 1'b1;
                            ctrl_idx_d = 2'd2;
                        end
                        default: go_vid = 1'b1;
                    endcase
                end
`endif
                VID_HDR: go_pix = 1'b1;
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase

            if (go_vid) begin
                state_d = VID_HDR;
                data_d  = '0;
                sop_d   = 1'b1;
                eop_d   = 1'b0;
                valid_d = 1'b1;
                mode_d  = mode;
                solid_d = solid_color;
            end

            if (go_pix) begin
                state_d = PIXELS;
                data_d  = pix;
                sop_d   = 1'b0;
                eop_d   = last_px;
                valid_d = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 16'd1;
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
`ifdef VGA_STREAM_CTRL_PKT_EN
            ctrl_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
`ifdef VGA_STREAM_CTRL_PKT_EN
            ctrl_idx_q <= ctrl_idx_d;
`endif
        end
    end

    assign m_data          = data_q;
    assign m_startofpacket = sop_q;
    assign m_endofpacket   = eop_q;
    assign m_empty         = 2'b00;
    assign m_valid         = valid_q;
    assign frame_done      = done_q;
    assign frame_count     = count_q;

endmodule

// File: tb/tb_vga_stream_master.sv
// Scoreboard bench for vga_stream_master at 16x4, 10-bit colour.
module tb_vga_stream_master;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int CB = 10;
    localparam int DW = 3 * CB;
`ifdef VGA_STREAM_CTRL_PKT_EN
    localparam int HB = 5;
`else
    localparam int HB = 1;
`endif

    logic          clk, reset, enable, m_ready;
    logic [1:0]    mode, m_empty;
    logic [DW-1:0] solid_color, m_data;
    logic          m_startofpacket, m_endofpacket, m_valid, frame_done;
    logic [15:0]   frame_count, exp_count;
    logic [DW+1:0] sb [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    vga_stream_master #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_BITS(CB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .solid_color(solid_color),
        .m_data(m_data), .m_startofpacket(m_startofpacket), .m_endofpacket(m_endofpacket),
        .m_empty(m_empty), .m_valid(m_valid), .m_ready(m_ready),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_pix(input logic [1:0] md, input logic [DW-1:0] sc,
                                              input int x, input int y);
        logic [2:0]    t [8];
        logic [DW-1:0] res;
        int            bw, b, xy;
        t  = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        bw = (H < 8) ? 1 : H / 8;
        b  = x / bw;
        if (b > 7) b = 7;
        xy = x ^ y;
        case (md)
            2'd0:    res = sc;
            2'd1:    res = {{CB{t[b][2]}}, {CB{t[b][1]}}, {CB{t[b][0]}}};
            2'd2:    res = {x[CB-1:0], y[CB-1:0], xy[CB-1:0]};
            default: res = (((x / 32) + (y / 32)) % 2 == 1) ? {DW{1'b0}} : {DW{1'b1}};
        endcase
        return res;
    endfunction

`ifdef VGA_STREAM_CTRL_PKT_EN
    function automatic logic [DW-1:0] nib3(input logic [3:0] s2, input logic [3:0] s1,
                                           input logic [3:0] s0);
        logic [DW-1:0] d;
        d = '0;
        d[3:0]         = s0;
        d[CB+3:CB]     = s1;
        d[2*CB+3:2*CB] = s2;
        return d;
    endfunction
`endif

    task automatic push_frame(input logic [1:0] md, input logic [DW-1:0] sc);
`ifdef VGA_STREAM_CTRL_PKT_EN
        logic [15:0] w, h;
        w = 16'(H);
        h = 16'(V);
        sb.push_back({2'b10, nib3(4'h0, 4'h0, 4'hF)});
        sb.push_back({2'b00, nib3(w[7:4], w[11:8], w[15:12])});
        sb.push_back({2'b00, nib3(h[11:8], h[15:12], w[3:0])});
        sb.push_back({2'b01, nib3(4'h3, h[3:0], h[7:4])});
`endif
        sb.push_back({2'b10, {DW{1'b0}}});
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                sb.push_back({1'b0, (x == H - 1 && y == V - 1), exp_pix(md, sc, x, y)});
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; m_ready = 1'b1; mode = 2'd0; solid_color = '0;
        exp_count = '0;
        repeat (3) cyc();
        n_cmp++;
        if ({m_valid, m_startofpacket, m_endofpacket, frame_done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got v/s/e/d=%b%b%b%b, required 0000",
                     m_valid, m_startofpacket, m_endofpacket, frame_done);
        end
        n_cmp++;
        if (m_data !== '0 || m_empty !== 2'b00 || frame_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data: got data=%h empty=%b count=%0d, required 0/0/0",
                     m_data, m_empty, frame_count);
        end
        reset = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_disabled: got valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_frame(input logic [1:0] md, input logic [DW-1:0] sc, input bit rnd,
                              input int nf);
        logic [DW+1:0] cur, prev, exp;
        logic          pv, pr;
        int            dones, gaps, tail, seen;
        pv = 1'b0; pr = 1'b1; prev = '0; dones = 0; gaps = 0; tail = 0; seen = 0;
        mode = md; solid_color = sc;
        for (int f = 0; f < nf; f++) push_frame(md, sc);
        enable = 1'b1;
        for (int c = 0; c < 600 && tail < 4; c++) begin
            cyc();
            m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            cur = {m_startofpacket, m_endofpacket, m_data};
            if (pv && !pr) begin
                n_cmp++;
                if (!m_valid || cur !== prev) begin
                    n_bad++;
                    $display("FAIL hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             m_valid, cur, prev);
                end
            end
            if (frame_done) dones++;
            if (m_valid) seen = 1;
            else if (seen != 0 && sb.size() > 0) gaps++;
            if (m_valid && m_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_beat: got %h, required none", cur);
                end else begin
                    exp = sb.pop_front();
                    if (cur !== exp) begin
                        n_bad++;
                        $display("FAIL beat_mode%0d: got %h, required %h", md, cur, exp);
                    end
                    if (sb.size() == 0) enable = 1'b0;
                end
            end
            pv = m_valid; pr = m_ready; prev = cur;
            if (sb.size() == 0) tail++;
        end
        exp_count = exp_count + 16'(nf);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_mode%0d: got %0d beats outstanding, required 0", md, sb.size());
        end
        n_cmp++;
        if (dones != nf) begin
            n_bad++;
            $display("FAIL frame_done: got %0d pulses, required %0d", dones, nf);
        end
        n_cmp++;
        if (frame_count !== exp_count) begin
            n_bad++;
            $display("FAIL frame_count: got %0d, required %0d", frame_count, exp_count);
        end
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL end_idle: got valid=%b, required 0", m_valid);
        end
        if (!rnd) begin
            n_cmp++;
            if (gaps != 0) begin
                n_bad++;
                $display("FAIL bubble: got %0d idle cycles, required 0", gaps);
            end
        end
        sb.delete();
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [DW+1:0] cur, exp;
        logic [DW-1:0] sc;
        int            k, tail;
        sc = {10'h155, 10'h0AA, 10'h2C3};
        m_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            mode = (f == 0) ? 2'd0 : 2'd3;
            solid_color = sc;
            push_frame(mode, sc);
            enable = 1'b1; k = 0; tail = 0;
            for (int c = 0; c < 300 && tail < 4; c++) begin
                cyc();
                cur = {m_startofpacket, m_endofpacket, m_data};
                if (m_valid) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL drop_extra: got %h, required none", cur);
                    end else begin
                        exp = sb.pop_front();
                        k++;
                        if (cur !== exp) begin
                            n_bad++;
                            $display("FAIL drop_beat_f%0d: got %h, required %h", f, cur, exp);
                        end
                    end
                    if (f == 0 && k == HB + 20) begin
                        enable = 1'b0;
                        mode = 2'd3;
                    end
                    if (sb.size() == 0) enable = 1'b0;
                end
                if (sb.size() == 0) begin
                    tail++;
                    if (tail > 1) begin
                        n_cmp++;
                        if (m_valid !== 1'b0) begin
                            n_bad++;
                            $display("FAIL drop_idle: got valid=%b, required 0", m_valid);
                        end
                    end
                end
            end
            n_cmp++;
            if (sb.size() != 0) begin
                n_bad++;
                $display("FAIL drop_timeout: got %0d beats outstanding, required 0", sb.size());
            end
            exp_count = exp_count + 16'd1;
            sb.delete();
        end
        n_cmp++;
        if (frame_count !== exp_count) begin
            n_bad++;
            $display("FAIL drop_count: got %0d, required %0d", frame_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW+1:0] cur, exp;
        int            k;
        k = 0; m_ready = 1'b1; mode = 2'd2; solid_color = '0;
        push_frame(2'd2, '0);
        enable = 1'b1;
        for (int c = 0; c < 200 && k < HB + 30; c++) begin
            cyc();
            cur = {m_startofpacket, m_endofpacket, m_data};
            if (m_valid && sb.size() > 0) begin
                n_cmp++;
                exp = sb.pop_front();
                k++;
                if (cur !== exp) begin
                    n_bad++;
                    $display("FAIL pre_reset_beat: got %h, required %h", cur, exp);
                end
            end
        end
        reset = 1'b1;
        enable = 1'b0;
        #1;
        n_cmp++;
        if (k != HB + 30) begin
            n_bad++;
            $display("FAIL pre_reset_timeout: got %0d beats, required %0d", k, HB + 30);
        end
        n_cmp++;
        if ({m_valid, m_startofpacket, m_endofpacket, frame_done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_flags: got v/s/e/d=%b%b%b%b, required 0000",
                     m_valid, m_startofpacket, m_endofpacket, frame_done);
        end
        n_cmp++;
        if (m_data !== '0 || m_empty !== 2'b00 || frame_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midreset_data: got data=%h empty=%b count=%0d, required 0/0/0",
                     m_data, m_empty, frame_count);
        end
        sb.delete();
        exp_count = '0;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got valid=%b, required 0", m_valid);
        end
        test_frame(2'd2, '0, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_frame(2'd0, {10'h3FF, 20'h0}, 1'b0, 1);
        test_frame(2'd1, '0, 1'b0, 1);
        test_frame(2'd2, '0, 1'b1, 1);
        test_frame(2'd1, '0, 1'b0, 2);
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
